// File: rtl/ram_share_arbiter.sv
// ram_share_arbiter: shares the single-port system RAM between the 6502 CPU,
// the VGA renderer's read bursts and the UART program loader's writes.
// The CPU is paused through RDY and only at an opcode fetch (SYNC). Before
// RDY returns, one RESUME cycle puts the CPU's frozen address back on the RAM
// so that the synchronous read data is valid when the CPU continues.
// Optional build macro: ARB_STATS_EN adds saturating stall/burst counters.
module ram_share_arbiter #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8
`ifdef ARB_STATS_EN
   ,
   parameter int STAT_W = 16
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_we,
   input  logic              cpu_sync,
   output logic              cpu_ready,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_grant,
   output logic              vid_rvalid,
   input  logic              ldr_req,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   input  logic              ldr_we,
   output logic              ldr_grant,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we
`ifdef ARB_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_cpu_stall,
   output logic [STAT_W-1:0] stat_vid_bursts
`endif
);

   typedef enum logic [1:0] {
      ST_RESUME = 2'd0,
      ST_CPU    = 2'd1,
      ST_VID    = 2'd2,
      ST_LDR    = 2'd3
   } state_t;

   state_t state_reg;
   logic   cpu_ready_reg;
   logic   vid_grant_reg;
   logic   ldr_grant_reg;
   logic   vid_rvalid_reg;

   // Ownership FSM; grants and RDY are registered alongside the state so they
   // always agree with the RAM mux below.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= ST_RESUME;
         cpu_ready_reg  <= 1'b0;
         vid_grant_reg  <= 1'b0;
         ldr_grant_reg  <= 1'b0;
         vid_rvalid_reg <= 1'b0;
      end else begin
         // RAM output is one cycle behind the address, so valid trails the grant
         vid_rvalid_reg <= (state_reg == ST_VID) && vid_req;
         case (state_reg)
            ST_RESUME: begin
               // requests are deliberately ignored here: the CPU always gets
               // at least one instruction between bursts
               state_reg     <= ST_CPU;
               cpu_ready_reg <= 1'b1;
            end
            ST_CPU: begin
               if ((vid_req || ldr_req) && cpu_sync) begin
                  cpu_ready_reg <= 1'b0;
                  if (vid_req) begin
                     state_reg     <= ST_VID;
                     vid_grant_reg <= 1'b1;
                  end else begin
                     state_reg     <= ST_LDR;
                     ldr_grant_reg <= 1'b1;
                  end
               end
            end
            ST_VID: begin
               if (!vid_req) begin
                  vid_grant_reg <= 1'b0;
                  if (ldr_req) begin
                     state_reg     <= ST_LDR;
                     ldr_grant_reg <= 1'b1;
                  end else begin
                     state_reg <= ST_RESUME;
                  end
               end
            end
            ST_LDR: begin
               // video preempts the loader; the write in this cycle still lands
               if (vid_req) begin
                  state_reg     <= ST_VID;
                  ldr_grant_reg <= 1'b0;
                  vid_grant_reg <= 1'b1;
               end else if (!ldr_req) begin
                  state_reg     <= ST_RESUME;
                  ldr_grant_reg <= 1'b0;
               end
            end
            default: begin
               state_reg     <= ST_RESUME;
               cpu_ready_reg <= 1'b0;
               vid_grant_reg <= 1'b0;
               ldr_grant_reg <= 1'b0;
            end
         endcase
      end
   end

   // RAM port mux on the current owner; RESUME re-presents the CPU address read-only.
   always_comb begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = 1'b0;
      case (state_reg)
         ST_CPU: ram_we = cpu_we & cpu_ready_reg;
         ST_VID: ram_addr = vid_addr;
         ST_LDR: begin
            ram_addr  = ldr_addr;
            ram_wdata = ldr_wdata;
            ram_we    = ldr_we;
         end
         default: ram_we = 1'b0;
      endcase
   end

   assign cpu_ready  = cpu_ready_reg;
   assign vid_grant  = vid_grant_reg;
   assign ldr_grant  = ldr_grant_reg;
   assign vid_rvalid = vid_rvalid_reg;

`ifdef ARB_STATS_EN
   logic              enter_vid;
   logic [STAT_W-1:0] stall_cnt_reg;
   logic [STAT_W-1:0] burst_cnt_reg;

   // VID is entered only from CPU (at SYNC) or by preempting the loader
   assign enter_vid = ((state_reg == ST_CPU) && cpu_sync && vid_req) ||
                      ((state_reg == ST_LDR) && vid_req);

   // Saturating statistics counters, cleared by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_reg <= '0;
         burst_cnt_reg <= '0;
      end else begin
         if (!cpu_ready_reg && (stall_cnt_reg != {STAT_W{1'b1}}))
            stall_cnt_reg <= stall_cnt_reg + STAT_W'(1);
         if (enter_vid && (burst_cnt_reg != {STAT_W{1'b1}}))
            burst_cnt_reg <= burst_cnt_reg + STAT_W'(1);
      end
   end

   assign stat_cpu_stall  = stall_cnt_reg;
   assign stat_vid_bursts = burst_cnt_reg;
`endif

endmodule

// File: tb/tb_ram_share_arbiter.sv
// Directed bench for ram_share_arbiter with a small synchronous RAM model.
module tb_ram_share_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_we;
   logic        cpu_sync;
   logic        cpu_ready;
   logic        vid_req;
   logic [10:0] vid_addr;
   logic        vid_grant;
   logic        vid_rvalid;
   logic        ldr_req;
   logic [10:0] ldr_addr;
   logic [7:0]  ldr_wdata;
   logic        ldr_we;
   logic        ldr_grant;
   logic [10:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic        ram_we;
`ifdef ARB_STATS_EN
   logic [15:0] stat_cpu_stall;
   logic [15:0] stat_vid_bursts;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   ram_share_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_we     (cpu_we),
      .cpu_sync   (cpu_sync),
      .cpu_ready  (cpu_ready),
      .vid_req    (vid_req),
      .vid_addr   (vid_addr),
      .vid_grant  (vid_grant),
      .vid_rvalid (vid_rvalid),
      .ldr_req    (ldr_req),
      .ldr_addr   (ldr_addr),
      .ldr_wdata  (ldr_wdata),
      .ldr_we     (ldr_we),
      .ldr_grant  (ldr_grant),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_we     (ram_we)
`ifdef ARB_STATS_EN
      ,
      .stat_cpu_stall  (stat_cpu_stall),
      .stat_vid_bursts (stat_vid_bursts)
`endif
   );

   always #5 clk = ~clk;

   // preload pattern for bytes never written during the run
   function automatic logic [7:0] pre_byte(input logic [10:0] a);
      return a[7:0] ^ 8'hA5;
   endfunction

   // synchronous single-port RAM model
   logic [7:0] mem [0:2047];
   bit         written [0:2047];
   logic [7:0] ram_dout;
   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr]     <= ram_wdata;
         written[ram_addr] <= 1'b1;
      end
      ram_dout <= written[ram_addr] ? mem[ram_addr] : pre_byte(ram_addr);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; cpu_addr = 11'h123; cpu_wdata = 8'h3C; cpu_we = 1'b0; cpu_sync = 1'b0;
      vid_req = 1'b0; vid_addr = 11'h000; ldr_req = 1'b0; ldr_addr = 11'h000;
      ldr_wdata = 8'h00; ldr_we = 1'b0;

      // ---- reset state
      #3;
      check("rst_cpu_ready", 32'(cpu_ready), 32'h0);
      check("rst_vid_grant", 32'(vid_grant), 32'h0);
      check("rst_ldr_grant", 32'(ldr_grant), 32'h0);
      check("rst_vid_rvalid", 32'(vid_rvalid), 32'h0);
      check("rst_ram_we", 32'(ram_we), 32'h0);
      check("rst_ram_addr", 32'(ram_addr), 32'h123);

      // ---- release: one RESUME cycle, then CPU
      tick; reset = 1'b1; #1;
      check("resume_ready", 32'(cpu_ready), 32'h0);
      check("resume_addr", 32'(ram_addr), 32'h123);
      tick;
      cpu_addr = 11'h045; cpu_we = 1'b1; #1;
      check("cpu_ready_up", 32'(cpu_ready), 32'h1);
      check("cpu_addr_mux", 32'(ram_addr), 32'h045);
      check("cpu_we_mux", 32'(ram_we), 32'h1);
      check("cpu_wdata_mux", 32'(ram_wdata), 32'h3C);
`ifdef ARB_STATS_EN
      check("stat_stall_first", 32'(stat_cpu_stall), 32'h1);
`endif

      // ---- video request waits for SYNC
      tick; cpu_we = 1'b0; vid_req = 1'b1; vid_addr = 11'h200; #1;
      check("wait_no_grant", 32'(vid_grant), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick;
         check($sformatf("wait_ready_%0d", i), 32'(cpu_ready), 32'h1);
         check($sformatf("wait_grant_%0d", i), 32'(vid_grant), 32'h0);
      end
      cpu_sync = 1'b1; #1;
      check("sync_ready", 32'(cpu_ready), 32'h1);
      tick; cpu_sync = 1'b0; #1;
      check("vid_ready_low", 32'(cpu_ready), 32'h0);
      check("vid_grant_up", 32'(vid_grant), 32'h1);
      check("vid_we_low", 32'(ram_we), 32'h0);
`ifdef ARB_STATS_EN
      check("stat_burst_1", 32'(stat_vid_bursts), 32'h1);
`endif

      // ---- 8-address burst 0x200..0x207
      for (int i = 0; i < 8; i++) begin
         vid_addr = 11'h200 + 11'(i); #1;
         check($sformatf("burst_grant_%0d", i), 32'(vid_grant), 32'h1);
         check($sformatf("burst_addr_%0d", i), 32'(ram_addr), 32'h200 + 32'(i));
         if (i == 0) begin
            check("burst_rvalid_0", 32'(vid_rvalid), 32'h0);
         end else begin
            check($sformatf("burst_rvalid_%0d", i), 32'(vid_rvalid), 32'h1);
            check($sformatf("burst_data_%0d", i), 32'(ram_dout),
                  32'(pre_byte(11'h200 + 11'(i - 1))));
         end
         tick;
      end
      vid_req = 1'b0; #1;
      check("burst_rvalid_last", 32'(vid_rvalid), 32'h1);
      check("burst_data_last", 32'(ram_dout), 32'h07 ^ 32'hA5);
      check("burst_tail_grant", 32'(vid_grant), 32'h1);
      tick;
      check("post_vid_grant", 32'(vid_grant), 32'h0);
      check("post_vid_rvalid", 32'(vid_rvalid), 32'h0);
      check("post_vid_resume", 32'(cpu_ready), 32'h0);
      check("post_vid_addr", 32'(ram_addr), 32'h045);
      tick;
      check("post_vid_ready", 32'(cpu_ready), 32'h1);

      // ---- simultaneous requests: VID, then LDR, then RESUME
      vid_req = 1'b1; vid_addr = 11'h300; ldr_req = 1'b1; ldr_addr = 11'h600;
      ldr_wdata = 8'h55; ldr_we = 1'b1; cpu_sync = 1'b1; #1;
      check("both_no_ldr_grant", 32'(ldr_grant), 32'h0);
      tick; cpu_sync = 1'b0; #1;
      check("both_vid_first", 32'(vid_grant), 32'h1);
      check("both_ldr_wait", 32'(ldr_grant), 32'h0);
      check("both_vid_we", 32'(ram_we), 32'h0);
      tick; vid_req = 1'b0; #1;
      check("both_vid_tail", 32'(vid_grant), 32'h1);
      tick;
      check("both_ldr_grant", 32'(ldr_grant), 32'h1);
      check("both_vid_off", 32'(vid_grant), 32'h0);
      check("both_ldr_we", 32'(ram_we), 32'h1);
      check("both_ldr_addr", 32'(ram_addr), 32'h600);
      check("both_ldr_wdata", 32'(ram_wdata), 32'h55);
      tick; ldr_req = 1'b0; ldr_we = 1'b0; cpu_addr = 11'h600; #1;
      check("both_ldr_hold", 32'(ldr_grant), 32'h1);
      check("both_ldr_we_off", 32'(ram_we), 32'h0);
      tick;
      check("both_resume_grant", 32'(ldr_grant), 32'h0);
      check("both_resume_ready", 32'(cpu_ready), 32'h0);
      check("both_resume_addr", 32'(ram_addr), 32'h600);
      tick;
      check("both_cpu_ready", 32'(cpu_ready), 32'h1);
      check("both_cpu_readback", 32'(ram_dout), 32'h55);

      // ---- loader preempted by video, then resumes
      ldr_req = 1'b1; ldr_addr = 11'h610; ldr_wdata = 8'h66; ldr_we = 1'b1; cpu_sync = 1'b1;
      tick; cpu_sync = 1'b0; vid_req = 1'b1; vid_addr = 11'h210; #1;
      check("pre_ldr_grant", 32'(ldr_grant), 32'h1);
      check("pre_ldr_we", 32'(ram_we), 32'h1);
      check("pre_ldr_addr", 32'(ram_addr), 32'h610);
      tick; ldr_addr = 11'h611; ldr_wdata = 8'h77; #1;
      check("pre_ldr_dropped", 32'(ldr_grant), 32'h0);
      check("pre_vid_grant", 32'(vid_grant), 32'h1);
      check("pre_vid_we", 32'(ram_we), 32'h0);
      check("pre_vid_addr", 32'(ram_addr), 32'h210);
      tick; vid_req = 1'b0; #1;
      check("pre_vid_rvalid", 32'(vid_rvalid), 32'h1);
      check("pre_vid_data", 32'(ram_dout), 32'h10 ^ 32'hA5);
      tick;
      check("pre_ldr_back", 32'(ldr_grant), 32'h1);
      check("pre_ldr_back_vid", 32'(vid_grant), 32'h0);
      check("pre_ldr_back_addr", 32'(ram_addr), 32'h611);
      check("pre_ldr_back_wdata", 32'(ram_wdata), 32'h77);
      tick; ldr_req = 1'b0; ldr_we = 1'b0; cpu_addr = 11'h610; #1;
      tick;
      check("pre_resume_ready", 32'(cpu_ready), 32'h0);
      check("pre_resume_grant", 32'(ldr_grant), 32'h0);
      tick; cpu_addr = 11'h611; #1;
      check("pre_rd_610", 32'(ram_dout), 32'h66);
      tick;
      check("pre_rd_611", 32'(ram_dout), 32'h77);
`ifdef ARB_STATS_EN
      check("stat_burst_3", 32'(stat_vid_bursts), 32'h3);
`endif

      // ---- reset asserted mid-VID with the loader also writing
      vid_req = 1'b1; vid_addr = 11'h220; cpu_sync = 1'b1;
      ldr_req = 1'b1; ldr_we = 1'b1;
      tick; cpu_sync = 1'b0; #1;
      check("mid_vid_grant", 32'(vid_grant), 32'h1);
      tick;
      check("mid_vid_rvalid", 32'(vid_rvalid), 32'h1);
      #1 reset = 1'b0; #1;
      check("arst_vid_grant", 32'(vid_grant), 32'h0);
      check("arst_ldr_grant", 32'(ldr_grant), 32'h0);
      check("arst_ram_we", 32'(ram_we), 32'h0);
      check("arst_cpu_ready", 32'(cpu_ready), 32'h0);
      check("arst_vid_rvalid", 32'(vid_rvalid), 32'h0);
`ifdef ARB_STATS_EN
      check("arst_stat_stall", 32'(stat_cpu_stall), 32'h0);
      check("arst_stat_burst", 32'(stat_vid_bursts), 32'h0);
`endif
      vid_req = 1'b0; ldr_req = 1'b0; ldr_we = 1'b0;
      tick; tick;
      check("hold_rst_ram_we", 32'(ram_we), 32'h0);
`ifdef ARB_STATS_EN
      check("hold_rst_stall", 32'(stat_cpu_stall), 32'h0);
`endif
      reset = 1'b1; #1;
      tick;
      check("rerun_ready", 32'(cpu_ready), 32'h1);
`ifdef ARB_STATS_EN
      check("rerun_stall_1", 32'(stat_cpu_stall), 32'h1);
      vid_req = 1'b1; cpu_sync = 1'b1;
      tick; vid_req = 1'b0; cpu_sync = 1'b0; #1;
      check("rerun_stall_hold", 32'(stat_cpu_stall), 32'h1);
      check("rerun_burst_1", 32'(stat_vid_bursts), 32'h1);
      tick; tick;
      check("rerun_stall_3", 32'(stat_cpu_stall), 32'h3);
      check("rerun_ready_back", 32'(cpu_ready), 32'h1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
